// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - programmable note-table tone sequencer with PWM audio output
module tone_sequencer #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SEQ_LEN     = 8,
    parameter int NOTE_CYCLES = 134_217_728,
    parameter int GAP_CYCLES  = 0,
    parameter int CNT_W       = 20,
    localparam int AW         = $clog2(SEQ_LEN)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [1:0]    octave,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_data,
    output logic          aud_pwm,
    output logic          aud_sd,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] note_idx,
    output logic [9:0]    LED
);

    localparam int   DW       = $clog2(NOTE_CYCLES);
    localparam int   GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int   GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic HAS_GAP  = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

    state_t           state_q;
    logic [AW-1:0]    idx_q;
    logic [2:0]       code_q;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] tone_q;
    logic [DW-1:0]    dur_q;
    logic [GW-1:0]    gap_q;
    logic             pwm_q;
    logic             busy_q;
    logic             done_q;
    logic [9:0]       led_q;
    logic [2:0]       table_q [SEQ_LEN];

    logic             last_entry;
    logic [AW-1:0]    entry_idx;
    logic [2:0]       entry_code;
    logic [CNT_W-1:0] shifted;
    logic [CNT_W-1:0] entry_half;
    logic [9:0]       entry_led;
    logic             note_end;
    logic             gap_end;
    logic             decide;
    logic             go_note;
    logic             seq_end;
    logic             go_idle;

    // Half-period of each diatonic note in clock cycles; rest has none.
    function automatic logic [CNT_W-1:0] base_half(input logic [2:0] code);
        case (code)
            3'd0:    base_half = CNT_W'(CLK_HZ / (2 * 523));
            3'd1:    base_half = CNT_W'(CLK_HZ / (2 * 587));
            3'd2:    base_half = CNT_W'(CLK_HZ / (2 * 659));
            3'd3:    base_half = CNT_W'(CLK_HZ / (2 * 698));
            3'd4:    base_half = CNT_W'(CLK_HZ / (2 * 783));
            3'd5:    base_half = CNT_W'(CLK_HZ / (2 * 880));
            3'd6:    base_half = CNT_W'(CLK_HZ / (2 * 987));
            default: base_half = '0;
        endcase
    endfunction

    // Select the entry to play next and decide when the current entry/gap ends.
    always_comb begin
        last_entry = (idx_q == AW'(SEQ_LEN - 1));
        entry_idx  = (state_q == S_IDLE || last_entry) ? '0 : idx_q + 1'b1;
        entry_code = table_q[entry_idx];
        shifted    = base_half(entry_code) >> octave;
        entry_half = (shifted == '0) ? CNT_W'(1) : shifted;
        entry_led  = 10'h200 | (10'b1 << entry_code);
        note_end   = (state_q == S_NOTE) && (dur_q == DW'(NOTE_CYCLES - 1));
        gap_end    = (state_q == S_GAP) && (gap_q == GW'(GAP_LAST));
        decide     = (note_end && !HAS_GAP) || gap_end;
        go_note    = (state_q == S_IDLE && start && !stop) ||
                     (state_q != S_IDLE && !stop && decide && (!last_entry || loop_en));
        seq_end    = (state_q != S_IDLE) && !stop && decide && last_entry && !loop_en;
        go_idle    = (state_q != S_IDLE && stop) || seq_end;
    end

    // Sequencer FSM: note/gap timing, tone generation and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            code_q  <= '0;
            half_q  <= '0;
            tone_q  <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            pwm_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (go_note) begin
                state_q <= S_NOTE;
                idx_q   <= entry_idx;
                code_q  <= entry_code;
                half_q  <= entry_half;
                tone_q  <= entry_half - 1'b1;
                dur_q   <= '0;
                gap_q   <= '0;
                pwm_q   <= 1'b0;
                busy_q  <= 1'b1;
                led_q   <= entry_led;
            end else if (go_idle) begin
                state_q <= S_IDLE;
                idx_q   <= '0;
                tone_q  <= '0;
                dur_q   <= '0;
                gap_q   <= '0;
                pwm_q   <= 1'b0;
                busy_q  <= 1'b0;
                led_q   <= '0;
                done_q  <= seq_end;
            end else if (note_end) begin
                state_q <= S_GAP;
                gap_q   <= '0;
                pwm_q   <= 1'b0;
                led_q   <= 10'h200;
            end else if (state_q == S_NOTE) begin
                dur_q <= dur_q + 1'b1;
                if (code_q == 3'd7) begin
                    pwm_q <= 1'b0;
                end else if (tone_q == '0) begin
                    pwm_q  <= ~pwm_q;
                    tone_q <= half_q - 1'b1;
                end else begin
                    tone_q <= tone_q - 1'b1;
                end
            end else if (state_q == S_GAP) begin
                gap_q <= gap_q + 1'b1;
            end
        end
    end

    // Note table: reset to the C..B,rest pattern; out-of-range writes dropped.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                table_q[i] <= 3'(i % 8);
            end
        end else if (wr_en && ({1'b0, wr_addr} < (AW + 1)'(SEQ_LEN))) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    assign aud_pwm  = pwm_q;
    assign aud_sd   = busy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign note_idx = idx_q;
    assign LED      = led_q;

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Programmable tone sequencer for the board audio path. It steps through a SEQ_LEN-entry writable note table of seven diatonic notes (C5–B5) plus rest. Each note plays for a fixed duration, followed by an optional silent gap. It adds start/stop control, looping, octave transposition, amplifier shutdown when idle and a done pulse. It drives the PWM audio pin, amplifier shutdown pin and board LEDs directly.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz; sets the tone half-period table.
- SEQ_LEN, 8, number of note table entries (2..64); AW = clog2(SEQ_LEN).
- NOTE_CYCLES, 134_217_728, clock cycles each entry spends in NOTE (≥2).
- GAP_CYCLES, 0, silent cycles after each note (0 = no GAP state visit).
- CNT_W, 20, tone counter width; must hold CLK_HZ/1046.
- clock  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  level-sampled; starts playback from entry 0 when idle.
- stop  in  1  aborts playback; wins over start in the same cycle.
- loop_en  in  1  replay from entry 0 after the last entry instead of finishing.
- octave  in  2  transposition; the half-period is shifted right by octave.
- wr_en  in  1  note table write strobe.
- wr_addr  in  AW  table write address; writes with wr_addr ≥ SEQ_LEN are ignored.
- wr_data  in  3  note code: 0=C 523, 1=D 587, 2=E 659, 3=F 698, 4=G 783, 5=A 880, 6=B 987 Hz, 7=rest.
- aud_pwm  out  1  square-wave audio.
- aud_sd  out  1  amplifier enable (1 = on); equals busy.
- busy  out  1  high in NOTE or GAP.
- done  out  1  one-cycle pulse on natural end of a non-looping sequence.
- note_idx  out  AW  index of the entry playing; 0 when idle.
- LED  out  10  LED[k] = note code k one-hot during NOTE; LED[9] = busy; all zero when idle.

## Operation
- Half-period table: HALF[n] = floor(CLK_HZ / (2·f_n)) for codes 0..6, computed at elaboration.
- Effective half-period is max(HALF[code] >> octave, 1).
- Note table is held in registers. Reset contents: entry i = i mod 8, so the sequence is C D E F G A B rest, repeating.
- A write takes effect the cycle after wr_en. Writes are allowed while busy.
- Code and octave are latched on entry to NOTE. A write to the entry currently playing applies on that entry's next visit.
- States: IDLE, NOTE, GAP.
- IDLE → NOTE: start=1 and stop=0. idx=0, duration counter cleared, tone counter loaded with eff_half−1, aud_pwm=0.
- NOTE: the duration counter increments each cycle. The tone counter decrements; at 0, aud_pwm toggles and the counter reloads eff_half−1.
- Rest (code 7): aud_pwm is held 0 and no toggles occur.
- NOTE → GAP after NOTE_CYCLES cycles if GAP_CYCLES>0; otherwise the next-entry decision is taken directly.
- GAP: aud_pwm=0 for GAP_CYCLES cycles, then the next-entry decision.
- Next-entry decision:
  - idx < SEQ_LEN−1: NOTE with idx+1.
  - Last entry and loop_en=1 (sampled at the decision cycle): NOTE with idx=0.
  - Otherwise: IDLE with done=1 for one cycle.
- stop=1 in NOTE or GAP: IDLE next cycle, aud_pwm=0, done not asserted.
- start while busy is ignored. start held high in IDLE restarts playback immediately after done.

## Timing
- Reset values: state IDLE, aud_pwm 0, aud_sd 0, busy 0, done 0, note_idx 0, LED 0, all counters 0.
- Start latency: start sampled at edge k gives busy=1, aud_sd=1 and the LED pattern after edge k+1.
- First aud_pwm rise occurs eff_half cycles after NOTE entry; tone period is 2·eff_half cycles exactly.
- Each entry occupies exactly NOTE_CYCLES + GAP_CYCLES cycles, with no dead cycles between entries.
- The tone phase restarts (aud_pwm=0) at every NOTE entry.
- Reset mid-operation: all outputs return to reset values asynchronously; the note table returns to its reset contents.

## Test plan
- Bench params CLK_HZ=10_460, NOTE_CYCLES=64, GAP_CYCLES=4, SEQ_LEN=8. Pulse start → entry 0 toggles every 10 cycles (period 20). LED=0x201. done pulses exactly 8·68 cycles after busy rises. busy and aud_sd then fall to 0.
- Write entry 2 = 6, entry 3 = 7, octave=1, then start → entry 2 has half-period floor(10460/1974)>>1 = 2. Entry 3 produces no toggles with LED=0x280.
- loop_en=1 → after entry 7, note_idx wraps to 0 with no done pulse and no gap in busy. Clearing loop_en during the last entry → done fires at the end of that entry.
- stop asserted mid-note at entry 4 → IDLE next cycle; aud_pwm, LED, aud_sd all 0; done stays 0. start and stop in the same IDLE cycle → stays IDLE.
- resetn low for 1 cycle mid-GAP → outputs return to reset values immediately. The note table reads back the reset contents on the next playback.
- octave=3 on code 6 (HALF=5) → effective half-period 1 (clamped), aud_pwm toggles every cycle.
